// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with
// start/busy/done handshake, two's-complement input mode and overflow flag.
module binary_to_bcd_seq #(
    parameter int BIN_W  = 36,
    parameter int DIGITS = 11
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [BIN_W-1:0]      data,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  negative,
    output logic                  overflow
);

    localparam int CW = $clog2(BIN_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]          state;
    logic [BIN_W-1:0]    mag;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       cnt;
    logic                neg;
    logic                ovf_int;
    logic                in_neg;

    assign in_neg = signed_mode & data[BIN_W-1];

    // Add-3 correction on every digit that would reach >= 10 after doubling.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // busy is registered so it stays high through the done cycle and only
    // drops one edge later, unless a new start is taken on that same edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            mag      <= '0;
            scratch  <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            ovf_int  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mag     <= in_neg ? (~data + 1'b1) : data;
                        neg     <= in_neg;
                        scratch <= '0;
                        ovf_int <= 1'b0;
                        cnt     <= CW'(BIN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Top-digit carry-out means the magnitude exceeds 10^DIGITS-1.
                    {scratch, mag} <= {adj[4*DIGITS-2:0], mag, 1'b0};
                    ovf_int        <= ovf_int | adj[4*DIGITS-1];
                    cnt            <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= DONE;
                end
                DONE: begin
                    bcd      <= scratch;
                    negative <= neg;
                    overflow <= ovf_int;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
